// File: rtl/param_stream_loader.sv
// rtl/param_stream_loader.sv - host word stream loader for CNN/FC parameter banks and image buffer
// Raw modes copy beats straight to the write port; mode 11 run-length expands into packed image words.
module param_stream_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int CNN_WORDS = 50704,
    parameter int FC_WORDS  = 11218,
    parameter int IMG_BITS  = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              finish_cnn,
    output logic              finish_fc,
    output logic              done,
    output logic              error
);
    localparam int IMG_WORDS = IMG_BITS / DATA_W;
    localparam int WCNT_W    = ADDR_W + 1;
    localparam int FILL_W    = $clog2(DATA_W + 1);
    localparam int RUN_W     = DATA_W - 1;
    localparam int TOT_W     = $clog2(IMG_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_FLUSH, S_FIN} state_t;
    state_t state, state_nx;

    logic [1:0]        mode_q;
    logic [WCNT_W-1:0] wcnt;
    logic [FILL_W-1:0] fill;
    logic [DATA_W-1:0] pack;
    logic              run_bit;
    logic              run_last;
    logic [RUN_W-1:0]  run_rem;
    logic [TOT_W-1:0]  total;

    logic              is_rle;
    logic              accept;
    logic [1:0]        region;
    logic [WCNT_W-1:0] target;
    logic [WCNT_W-1:0] wcnt_inc;
    logic              raw_full;
    logic              raw_short;
    logic [RUN_W-1:0]  in_run;
    logic [FILL_W-1:0] room;
    logic [FILL_W-1:0] n;
    logic [FILL_W-1:0] fill_nx;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] pack_nx;
    logic [RUN_W-1:0]  rem_nx;
    logic [TOT_W-1:0]  total_nx;
    logic              img_full;
    logic              run_done;

    always_comb begin
        is_rle   = (mode_q == 2'b11);
        region   = mode_q[1] ? 2'b10 : mode_q;
        in_ready = (state == S_LOAD);
        busy     = (state != S_IDLE);
        accept   = in_valid && in_ready;
        case (mode_q)
            2'b00:   target = WCNT_W'(CNN_WORDS);
            2'b01:   target = WCNT_W'(FC_WORDS);
            default: target = WCNT_W'(IMG_WORDS);
        endcase
        wcnt_inc  = wcnt + WCNT_W'(1);
        raw_full  = (wcnt_inc == target);
        raw_short = in_last && !raw_full;
        in_run    = in_data[RUN_W-1:0];
        // Bits appended this cycle never cross a word boundary, so the image end is word aligned.
        room = FILL_W'(DATA_W) - fill;
        if (RUN_W'(room) > run_rem) begin
            n = run_rem[FILL_W-1:0];
        end else begin
            n = room;
        end
        fill_nx  = fill + n;
        mask     = ({DATA_W{1'b1}} >> fill) & ~({DATA_W{1'b1}} >> fill_nx);
        pack_nx  = run_bit ? (pack | mask) : pack;
        rem_nx   = run_rem - RUN_W'(n);
        total_nx = total + TOT_W'(n);
        img_full = (total_nx == TOT_W'(IMG_BITS));
        run_done = (rem_nx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (!is_rle) begin
                        if (raw_full || in_last) state_nx = S_FIN;
                    end else if (in_run != '0) begin
                        state_nx = S_EXPAND;
                    end else if (in_last) begin
                        state_nx = S_FLUSH;
                    end
                end
            end
            S_EXPAND: begin
                if (img_full) begin
                    state_nx = S_FIN;
                end else if (run_done) begin
                    state_nx = run_last ? S_FLUSH : S_LOAD;
                end
            end
            S_FLUSH: state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            wcnt       <= '0;
            fill       <= '0;
            pack       <= '0;
            run_bit    <= 1'b0;
            run_last   <= 1'b0;
            run_rem    <= '0;
            total      <= '0;
            wr_en      <= 1'b0;
            wr_sel     <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            finish_cnn <= 1'b0;
            finish_fc  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        wcnt   <= '0;
                        fill   <= '0;
                        pack   <= '0;
                        total  <= '0;
                        error  <= 1'b0;
                        case (mode)
                            2'b00:   finish_cnn <= 1'b0;
                            2'b01:   finish_fc  <= 1'b0;
                            default: done       <= 1'b0;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!is_rle) begin
                            wr_en   <= 1'b1;
                            wr_sel  <= region;
                            wr_addr <= wcnt[ADDR_W-1:0];
                            wr_data <= in_data;
                            wcnt    <= wcnt_inc;
                            if (raw_short) error <= 1'b1;
                        end else begin
                            run_bit  <= in_data[DATA_W-1];
                            run_rem  <= in_run;
                            run_last <= in_last;
                            if ((in_run == '0) && in_last) error <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    run_rem <= rem_nx;
                    total   <= total_nx;
                    if (fill_nx == FILL_W'(DATA_W)) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= 2'b10;
                        wr_addr <= wcnt[ADDR_W-1:0];
                        wr_data <= pack_nx;
                        wcnt    <= wcnt_inc;
                        fill    <= '0;
                        pack    <= '0;
                    end else begin
                        fill <= fill_nx;
                        pack <= pack_nx;
                    end
                    // Excess run bits past the image end, or a stream ending short, are length errors.
                    if (img_full ? !run_done : (run_done && run_last)) error <= 1'b1;
                end
                S_FLUSH: begin
                    if (fill != '0) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= 2'b10;
                        wr_addr <= wcnt[ADDR_W-1:0];
                        wr_data <= pack;
                        wcnt    <= wcnt_inc;
                    end
                end
                S_FIN: begin
                    if (!error) begin
                        case (mode_q)
                            2'b00:   finish_cnn <= 1'b1;
                            2'b01:   finish_fc  <= 1'b1;
                            default: done       <= 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_stream_loader.sv
// tb/tb_param_stream_loader.sv - self-checking bench for param_stream_loader
module tb_param_stream_loader;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int CNN_WORDS = 50704;
    localparam int FC_WORDS  = 11218;
    localparam int IMG_BITS  = 16384;
    localparam int NEVER     = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              finish_cnn;
    logic              finish_fc;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    param_stream_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNN_WORDS(CNN_WORDS),
        .FC_WORDS(FC_WORDS), .IMG_BITS(IMG_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .finish_cnn(finish_cnn), .finish_fc(finish_fc), .done(done), .error(error)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]  q_sel[$];
    logic [15:0] q_addr[$];
    logic [15:0] q_data[$];

    always @(negedge clk) begin
        if (wr_en) begin
            q_sel.push_back(wr_sel);
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
    end

    typedef struct {
        logic [63:0] beats;
        int          nb;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        err;
    } rle_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] written(input int i);
        if (i < q_data.size()) return {16'h0, q_data[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_writes(input string name, input logic [1:0] sel, input logic [15:0] exp[$]);
        int bad = 0;
        check({name, "_write_count"}, q_data.size(), exp.size());
        for (int i = 0; i < q_data.size() && i < exp.size(); i++)
            if (q_sel[i] !== sel || q_addr[i] !== 16'(i) || q_data[i] !== exp[i]) bad++;
        check({name, "_bad_writes"}, bad, 0);
    endtask

    // Expands runs into a flat bit list, then packs MSB-first into zero-padded words.
    function automatic void rle_model(input logic [15:0] beats[$], output logic [15:0] words[$],
                                      output bit err);
        bit          img[$];
        bit          excess = 0;
        logic [15:0] v;
        for (int i = 0; i < beats.size() && img.size() < IMG_BITS; i++)
            for (int k = 0; k < int'(beats[i][14:0]); k++)
                if (img.size() < IMG_BITS) img.push_back(beats[i][15]);
                else excess = 1;
        err = excess || (img.size() < IMG_BITS);
        words = {};
        for (int w = 0; w * 16 < img.size(); w++) begin
            v = '0;
            for (int b = 0; b < 16; b++)
                if (w * 16 + b < img.size()) v[15-b] = img[w*16+b];
            words.push_back(v);
        end
    endfunction

    task automatic run_load(input logic [1:0] m, input logic [15:0] beats[$], input int last_at,
                            input int valid_pct, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int limit;
        bit acc;
        limit = 4 * beats.size() + 4000;
        q_sel.delete();
        q_addr.delete();
        q_data.delete();
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared_by_start", error, 0);
        while (idx < beats.size() && idx < abort_at && busy && cyc < limit) begin
            in_valid = ($urandom_range(99) < valid_pct);
            in_data  = beats[idx];
            in_last  = (idx == last_at);
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        if (idx < abort_at) begin
            while (busy && cyc < limit) begin
                @(negedge clk);
                cyc++;
            end
            check("load_within_cycle_budget", cyc < limit, 1);
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        rle_vec_t    tbl[5];
        logic [15:0] beats[$];
        logic [15:0] exp_w[$];
        bit          exp_err;
        int          rem;
        int          len;
        bit          bv;

        tbl[0] = '{64'h8005_000B_8004_0000, 3, 2, 16'hF800, 16'hF000, 1'b1};
        tbl[1] = '{64'h8010_0000_0000_0000, 1, 1, 16'hFFFF, 16'h0000, 1'b1};
        tbl[2] = '{64'h0003_0000_8001_0000, 3, 1, 16'h1000, 16'h0000, 1'b1};
        tbl[3] = '{64'h8011_0000_0000_0000, 1, 2, 16'hFFFF, 16'h8000, 1'b1};
        tbl[4] = '{64'h0012_8002_0000_0000, 2, 2, 16'h0000, 16'h3000, 1'b1};

        rst_n = 1'b0; start = 1'b0; mode = '0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {in_ready, wr_en, wr_sel, busy, finish_cnn, finish_fc, done, error}, 0);
        check("reset_addr_data", {wr_addr, wr_data}, 0);
        rst_n = 1'b1;

        // Full CNN load, data = index
        beats = {};
        for (int i = 0; i < CNN_WORDS; i++) beats.push_back(16'(i));
        run_load(2'b00, beats, CNN_WORDS - 1, 100, NEVER);
        check_writes("cnn_full", 2'b00, beats);
        check("cnn_finish", finish_cnn, 1);
        check("cnn_error", error, 0);

        // FC load with 50% valid
        beats = {};
        for (int i = 0; i < FC_WORDS; i++) beats.push_back(16'($urandom));
        run_load(2'b01, beats, FC_WORDS - 1, 50, NEVER);
        check_writes("fc_full", 2'b01, beats);
        check("fc_finish", finish_fc, 1);
        check("fc_cnn_flag_kept", finish_cnn, 1);

        // Full RLE image: fixed prefix then random runs summing to the image size
        beats = {16'h8005, 16'h000B, 16'h0000};
        rem = IMG_BITS - 16;
        while (rem > 0) begin
            len = $urandom_range(1, 600);
            if (len > rem) len = rem;
            bv = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) beats.push_back({bv, 15'd0});
            beats.push_back({bv, 15'(len)});
            rem -= len;
        end
        rle_model(beats, exp_w, exp_err);
        run_load(2'b11, beats, beats.size() - 1, 70, NEVER);
        check_writes("rle_full", 2'b10, exp_w);
        check("rle_full_word0", written(0), 16'hF800);
        check("rle_full_done", done, !exp_err);
        check("rle_full_error", error, exp_err);

        // Short RLE streams ended by in_last
        for (int t = 0; t < 5; t++) begin
            beats = {};
            for (int i = 0; i < tbl[t].nb; i++) beats.push_back(tbl[t].beats[63-16*i -: 16]);
            run_load(2'b11, beats, tbl[t].nb - 1, 100, NEVER);
            rle_model(beats, exp_w, exp_err);
            check_writes($sformatf("rle_short%0d_model", t), 2'b10, exp_w);
            check($sformatf("rle_short%0d_count", t), q_data.size(), tbl[t].nw);
            check($sformatf("rle_short%0d_w0", t), written(0), tbl[t].w0);
            if (tbl[t].nw > 1) check($sformatf("rle_short%0d_w1", t), written(1), tbl[t].w1);
            check($sformatf("rle_short%0d_error", t), error, tbl[t].err);
            check($sformatf("rle_short%0d_done", t), done, 0);
        end

        // Raw CNN load cut short by in_last at beat 100
        beats = {};
        for (int i = 0; i < 200; i++) beats.push_back(16'($urandom));
        run_load(2'b00, beats, 99, 100, NEVER);
        beats = beats[0:99];
        check_writes("cnn_short", 2'b00, beats);
        check("cnn_short_error", error, 1);
        check("cnn_short_finish", finish_cnn, 0);
        check("cnn_short_fc_kept", finish_fc, 1);

        // Reset in the middle of an FC load, then a clean FC load
        beats = {};
        for (int i = 0; i < FC_WORDS; i++) beats.push_back(16'($urandom));
        run_load(2'b01, beats, FC_WORDS - 1, 100, 500);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {in_ready, wr_en, wr_sel, busy, finish_cnn, finish_fc, done, error}, 0);
        check("midreset_addr_data", {wr_addr, wr_data}, 0);
        repeat (2) @(negedge clk);
        check("midreset_no_writes", wr_en, 0);
        rst_n = 1'b1;
        run_load(2'b01, beats, FC_WORDS - 1, 100, NEVER);
        check_writes("fc_after_reset", 2'b01, beats);
        check("fc_after_reset_finish", finish_fc, 1);
        check("fc_after_reset_error", error, 0);
        check("fc_after_reset_cnn", finish_cnn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/param_stream_loader.md
Name: param_stream_loader

Overview:
- Parametrised, synthesizable successor to the accelerator's file-based I/O loader.
- Accepts a 16-bit word stream from the host over a valid/ready handshake and writes it into the CNN parameter bank, the FC parameter bank or the image buffer through one shared write port.
- Supports raw image load and on-the-fly run-length decompression of the image.
- Raises the per-region completion flags consumed by the controller: finish_cnn, finish_fc, done.

Parameters:
- DATA_W, 16, width of stream words and write-port data.
- ADDR_W, 16, write-port address width; must satisfy 2^ADDR_W >= max(CNN_WORDS, FC_WORDS, IMG_BITS/DATA_W).
- CNN_WORDS, 50704, words in a CNN parameter load.
- FC_WORDS, 11218, words in an FC parameter load.
- IMG_BITS, 16384, image size in bits; must be a multiple of DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- mode  in  2  sampled with start. 00 = CNN, 01 = FC, 10 = image raw, 11 = image RLE.
- in_data  in  DATA_W  stream word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final beat of the host transfer.
- in_ready  out  1  loader accepts the beat this cycle.
- wr_en  out  1  write strobe.
- wr_sel  out  2  destination: 00 = CNN bank, 01 = FC bank, 10 = image buffer.
- wr_addr  out  ADDR_W  word address within the selected bank.
- wr_data  out  DATA_W  write data.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is left.
- finish_cnn  out  1  sticky; CNN load completed without error.
- finish_fc  out  1  sticky; FC load completed without error.
- done  out  1  sticky; image load completed without error.
- error  out  1  sticky; length mismatch in the last load.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, FSM in IDLE, all counters 0. A reset mid-load aborts it; no further writes occur and no flags are set.
- A beat is accepted when in_valid and in_ready are both high.
- FSM states: IDLE, LOAD, EXPAND, FLUSH, FIN.
- IDLE:
  - in_ready = 0.
  - On start: latch mode, clear word count, clear fill and pack registers.
  - Clear error and the flag of the selected region only. Other regions' flags persist.
  - Go to LOAD.
  - start while not in IDLE is ignored.
- LOAD, raw modes (00, 01, 10):
  - in_ready = 1.
  - Each accepted beat produces, on the next cycle: wr_en = 1, wr_data = beat, wr_addr = beat index from 0, wr_sel = region. Latency is 1 cycle; throughput is 1 word/cycle.
  - Target count: CNN_WORDS, FC_WORDS, or IMG_BITS/DATA_W.
  - Accepting the beat that reaches the target count goes to FIN.
  - in_last before the target count: set error, go to FIN.
  - in_last absent on the final beat is not an error.
- LOAD, RLE mode (11):
  - Each beat encodes {bit value = in_data[DATA_W-1], run length = in_data[DATA_W-2:0]}.
  - Run length 0: consume the beat, produce nothing.
  - Otherwise latch the run, drop in_ready, go to EXPAND.
- EXPAND:
  - Each cycle, append n = min(run_remaining, DATA_W - fill) copies of the bit value to the pack register, MSB-first. Image bit 0 is bit DATA_W-1 of word 0.
  - When fill reaches DATA_W: write the word next cycle (wr_sel = 10, wr_addr = word index), then reset fill to 0.
  - Run exhausted with total < IMG_BITS: return to LOAD. If in_last accompanied that run: set error, go to FLUSH.
  - Total reaches IMG_BITS: go to FIN. Any excess run bits are discarded; error is set if excess > 0.
- FLUSH:
  - If fill > 0, write the partial word, zero-padded in its LSBs.
  - Then go to FIN.
- FIN:
  - One cycle, in_ready = 0.
  - If error = 0, set the region flag: finish_cnn (mode 00), finish_fc (01), or done (10/11).
  - Go to IDLE.
- Write port: a write and a beat acceptance in the same cycle are permitted. At most one write per cycle.
- Counters: all word and bit counters are saturating-free. Widths are sized from the parameters; wrap-around is impossible under the parameter constraints.

Test Plan:
- Reset, then start mode=00 and stream CNN_WORDS beats with data = index. Expect CNN_WORDS writes with wr_sel=0 and wr_addr=data=0..50703, finish_cnn=1, error=0, no write after the final beat.
- FC load with in_valid toggling 50% random. Expect FC_WORDS writes with contiguous addresses, finish_fc=1, finish_cnn still 1 from the prior load.
- RLE image with beats 0x8005, 0x000B, 0x0000, then runs completing 16384 bits. Expect word 0 = 0xF800, all runs reproduced bit-exact against a reference model, done=1, error=0.
- RLE image with in_last after 20 bits. Expect word 0 = expanded bits, word 1 zero-padded (4 bits valid), error=1, done=0.
- Raw CNN load with in_last at beat 100. Expect 100 writes, error=1, finish_cnn=0. A new start clears error.
- Assert rst_n low mid-FC-load at beat 500. Expect all outputs 0 immediately. Then a fresh start mode=01 load completes normally with addresses from 0.
